// File: rtl/control_pkg.sv
// control_pkg: shared encodings for the ARM-subset control unit.
//   - ALU operation codes driven on alu_ctrl
//   - instruction op field, DP cmd field and condition field codes
//   - immediate-format (imm_src) codes
//   - main_dec_t: bundle of the raw main-decode controls
package control_pkg;

    // ALU operation select
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_ORR = 4'b0011;
    localparam logic [3:0] ALU_EOR = 4'b0100;
    localparam logic [3:0] ALU_MOV = 4'b0101;
    localparam logic [3:0] ALU_LSL = 4'b0110;
    localparam logic [3:0] ALU_LSR = 4'b0111;
    localparam logic [3:0] ALU_ASR = 4'b1000;
    localparam logic [3:0] ALU_ROR = 4'b1001;

    // Instruction class, instr[27:26]
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_NOP = 2'b11;

    // Data-processing cmd, instr[24:21]
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    // Condition field, instr[31:28]
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    // Immediate extension format
    localparam logic [1:0] IMM_DP  = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;

    // Raw (ungated) controls produced by the main decoder
    typedef struct packed {
        logic       reg_w;
        logic       mem_w;
        logic       branch;
        logic       mem_reg;
        logic       alu_src;
        logic [1:0] imm_src;
        logic [1:0] reg_src;
    } main_dec_t;

endpackage

// File: rtl/cond_logic.sv
// cond_logic: NZCV flag register, condition evaluation and side-effect gating.
//   clk, rst       : clock, synchronous active-high reset (clears flags)
//   cond           : instruction condition field
//   alu_flags      : NZCV from the ALU for the current instruction
//   flag_w_nz/cv   : decoded flag-write requests for N,Z and C,V
//   reg_w, mem_w   : raw register / memory write requests
//   pc_w           : raw PC-redirect request (branch or write to R15)
//   reg_write, mem_write, pc_src : gated versions of the above
module cond_logic
    import control_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic       flag_w_nz,
    input  logic       flag_w_cv,
    input  logic       reg_w,
    input  logic       mem_w,
    input  logic       pc_w,
    output logic       reg_write,
    output logic       mem_write,
    output logic       pc_src
);

    logic [3:0] flags_q, flags_d;
    logic       n, z, c, v;
    logic       cond_ex;

    assign {n, z, c, v} = flags_q;

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = ~(n ^ v);
            COND_LT: cond_ex = n ^ v;
            COND_GT: cond_ex = ~z & ~(n ^ v);
            COND_LE: cond_ex = z | (n ^ v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // A failed condition suppresses the flag update along with every
    // other architectural side effect.
    always_comb begin
        flags_d = flags_q;
        if (cond_ex) begin
            if (flag_w_nz) flags_d[3:2] = alu_flags[3:2];
            if (flag_w_cv) flags_d[1:0] = alu_flags[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) flags_q <= 4'b0000;
        else     flags_q <= flags_d;
    end

    assign reg_write = reg_w & cond_ex & ~rst;
    assign mem_write = mem_w & cond_ex & ~rst;
    assign pc_src    = pc_w  & cond_ex & ~rst;

endmodule

// File: rtl/control_unit.sv
// control_unit: single-cycle ARM-subset controller.
//   clk, rst   : clock, synchronous active-high reset
//   cond, op, funct, rd, sh : instruction fields
//   alu_flags  : NZCV from the ALU
//   pc_src, reg_write, mem_write : condition-gated side effects
//   mem_reg, alu_src, imm_src, reg_src, alu_ctrl : ungated datapath selects
module control_unit
    import control_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic [3:0] rd,
    input  logic [1:0] sh,
    output logic       pc_src,
    output logic       reg_write,
    output logic       mem_write,
    output logic       mem_reg,
    output logic       alu_src,
    output logic [1:0] imm_src,
    output logic [1:0] reg_src,
    output logic [3:0] alu_ctrl
);

    main_dec_t  dec;
    logic [3:0] cmd;
    logic       no_wr;      // DP cmd that must not write Rd (CMP, unknown)
    logic       arith;      // DP cmd whose C/V are meaningful
    logic       is_cmp;
    logic       flag_w_nz, flag_w_cv;
    logic       reg_w;

    assign cmd = funct[4:1];

    // Main decode
    always_comb begin
        dec = '0;
        case (op)
            OP_DP: begin
                dec.reg_w   = 1'b1;
                dec.alu_src = funct[5];
                dec.imm_src = IMM_DP;
            end
            OP_MEM: begin
                dec.alu_src = 1'b1;
                dec.imm_src = IMM_MEM;
                if (funct[0]) begin
                    dec.reg_w   = 1'b1;
                    dec.mem_reg = 1'b1;
                end else begin
                    dec.mem_w   = 1'b1;
                    dec.reg_src = 2'b10;   // STR reads Rd as the store data
                end
            end
            OP_BR: begin
                dec.branch  = 1'b1;
                dec.alu_src = 1'b1;
                dec.imm_src = IMM_BR;
                dec.reg_src = 2'b01;       // branch target is PC-relative
            end
            default: dec = '0;
        endcase
    end

    // ALU decode and flag-write requests
    always_comb begin
        alu_ctrl  = ALU_ADD;
        no_wr     = 1'b0;
        arith     = 1'b0;
        is_cmp    = 1'b0;
        flag_w_nz = 1'b0;
        flag_w_cv = 1'b0;
        if (op == OP_DP) begin
            case (cmd)
                CMD_ADD: begin alu_ctrl = ALU_ADD; arith = 1'b1; end
                CMD_SUB: begin alu_ctrl = ALU_SUB; arith = 1'b1; end
                CMD_AND: alu_ctrl = ALU_AND;
                CMD_ORR: alu_ctrl = ALU_ORR;
                CMD_EOR: alu_ctrl = ALU_EOR;
                CMD_CMP: begin
                    alu_ctrl = ALU_SUB;
                    arith    = 1'b1;
                    is_cmp   = 1'b1;
                    no_wr    = 1'b1;
                end
                CMD_MOV: begin
                    // Register-form MOV is the shifter; sh picks the shift.
                    if (funct[5]) alu_ctrl = ALU_MOV;
                    else begin
                        case (sh)
                            2'b00:   alu_ctrl = ALU_LSL;
                            2'b01:   alu_ctrl = ALU_LSR;
                            2'b10:   alu_ctrl = ALU_ASR;
                            default: alu_ctrl = ALU_ROR;
                        endcase
                    end
                end
                default: begin alu_ctrl = ALU_ADD; no_wr = 1'b1; end
            endcase
            flag_w_nz = funct[0] | is_cmp;
            flag_w_cv = flag_w_nz & arith;
        end else if (op == OP_MEM) begin
            alu_ctrl = funct[3] ? ALU_ADD : ALU_SUB;   // U bit: add/sub offset
        end
    end

    assign reg_w   = dec.reg_w & ~no_wr;
    assign mem_reg = dec.mem_reg;
    assign alu_src = dec.alu_src;
    assign imm_src = dec.imm_src;
    assign reg_src = dec.reg_src;

    cond_logic u_cond_logic (
        .clk       (clk),
        .rst       (rst),
        .cond      (cond),
        .alu_flags (alu_flags),
        .flag_w_nz (flag_w_nz),
        .flag_w_cv (flag_w_cv),
        .reg_w     (reg_w),
        .mem_w     (dec.mem_w),
        .pc_w      (((rd == 4'd15) & reg_w) | dec.branch),
        .reg_write (reg_write),
        .mem_write (mem_write),
        .pc_src    (pc_src)
    );

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: randomized + directed checks of control_unit against a
// mnemonic-level reference model with its own NZCV flag copy.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] cond, alu_flags, rd;
    logic [1:0] op, sh;
    logic [5:0] funct;
    logic       pc_src, reg_write, mem_write, mem_reg, alu_src;
    logic [1:0] imm_src, reg_src;
    logic [3:0] alu_ctrl;

    int checks = 0;
    int errors = 0;
    logic [3:0] mflags = 4'b0000;   // model NZCV

    always #5 clk = ~clk;

    control_unit dut (
        .clk       (clk),
        .rst       (rst),
        .cond      (cond),
        .alu_flags (alu_flags),
        .op        (op),
        .funct     (funct),
        .rd        (rd),
        .sh        (sh),
        .pc_src    (pc_src),
        .reg_write (reg_write),
        .mem_write (mem_write),
        .mem_reg   (mem_reg),
        .alu_src   (alu_src),
        .imm_src   (imm_src),
        .reg_src   (reg_src),
        .alu_ctrl  (alu_ctrl)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic string mnem(input logic [1:0] o, input logic [5:0] f, input logic [1:0] s);
        string m;
        m = "NOP";
        if (o == 2'd0) begin
            case (f[4:1])
                4'd4:  m = "ADD";
                4'd2:  m = "SUB";
                4'd0:  m = "AND";
                4'd12: m = "ORR";
                4'd1:  m = "EOR";
                4'd10: m = "CMP";
                4'd13: begin
                    if (f[5]) m = "MOV";
                    else if (s == 2'd0) m = "LSL";
                    else if (s == 2'd1) m = "LSR";
                    else if (s == 2'd2) m = "ASR";
                    else m = "ROR";
                end
                default: m = "UNK";
            endcase
        end else if (o == 2'd1) m = f[0] ? "LDR" : "STR";
        else if (o == 2'd2) m = "B";
        return m;
    endfunction

    function automatic logic [3:0] alu_of(input string m, input logic u);
        case (m)
            "SUB", "CMP": return 4'd1;
            "AND": return 4'd2;
            "ORR": return 4'd3;
            "EOR": return 4'd4;
            "MOV": return 4'd5;
            "LSL": return 4'd6;
            "LSR": return 4'd7;
            "ASR": return 4'd8;
            "ROR": return 4'd9;
            "LDR", "STR": return u ? 4'd0 : 4'd1;
            default: return 4'd0;
        endcase
    endfunction

    function automatic bit passes(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Compare every output against the model at the negative edge.
    task automatic sample();
        string m;
        bit ex, writes_rd;
        @(negedge clk);
        m = mnem(op, funct, sh);
        ex = passes(cond, mflags) && !rst;
        writes_rd = (m == "ADD" || m == "SUB" || m == "AND" || m == "ORR" || m == "EOR" ||
                     m == "MOV" || m == "LSL" || m == "LSR" || m == "ASR" || m == "ROR" || m == "LDR");
        chk("reg_write", reg_write, writes_rd && ex);
        chk("mem_write", mem_write, (m == "STR") && ex);
        chk("pc_src",    pc_src,    ((writes_rd && rd == 4'd15) || m == "B") && ex);
        chk("mem_reg",   mem_reg,   m == "LDR");
        chk("alu_src",   alu_src,   (op == 2'd0 && funct[5]) || m == "LDR" || m == "STR" || m == "B");
        chk("imm_src",   imm_src,   (m == "LDR" || m == "STR") ? 2'b01 : (m == "B") ? 2'b10 : 2'b00);
        chk("reg_src",   reg_src,   (m == "STR") ? 2'b10 : (m == "B") ? 2'b01 : 2'b00);
        chk("alu_ctrl",  alu_ctrl,  alu_of(m, funct[3]));
    endtask

    // Advance one clock and update the model flags.
    task automatic tick();
        string m;
        logic [3:0] nxt;
        m = mnem(op, funct, sh);
        nxt = mflags;
        if (rst) nxt = 4'b0000;
        else if (passes(cond, mflags) && op == 2'd0 && (funct[0] || m == "CMP")) begin
            nxt[3:2] = alu_flags[3:2];
            if (m == "ADD" || m == "SUB" || m == "CMP") nxt[1:0] = alu_flags[1:0];
        end
        @(posedge clk);
        mflags = nxt;
        #1;
    endtask

    task automatic drive(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                         input logic [3:0] r, input logic [1:0] s, input logic [3:0] af);
        cond = c; op = o; funct = f; rd = r; sh = s; alu_flags = af;
    endtask

    initial begin
        rst = 1'b1;
        // Reset with arbitrary inputs: gated outputs must stay low.
        for (int i = 0; i < 2; i++) begin
            drive(4'hE, 2'b00, 6'b001001, 4'hF, 2'b00, 4'hF);
            sample();
            chk("rst_reg_write", reg_write, 0);
            chk("rst_pc_src", pc_src, 0);
            tick();
        end
        rst = 1'b0;

        // Flags must be 0000 after reset: probe every condition code.
        for (int c = 0; c < 16; c++) begin
            drive(c[3:0], 2'b00, 6'b001000, 4'h5, 2'b00, 4'h0);
            sample();
            tick();
        end

        // ADD / SUB register form
        drive(4'hE, 2'b00, 6'b001000, 4'h5, 2'b00, 4'h0);
        sample();
        chk("add_reg_write", reg_write, 1);
        chk("add_alu_ctrl", alu_ctrl, 4'b0000);
        tick();
        drive(4'hE, 2'b00, 6'b000100, 4'h5, 2'b00, 4'h0);
        sample();
        chk("sub_alu_ctrl", alu_ctrl, 4'b0001);
        tick();

        // CMP sets Z, then EQ executes and NE is suppressed.
        drive(4'hE, 2'b00, 6'b010101, 4'h5, 2'b00, 4'b0100);
        sample();
        chk("cmp_no_write", reg_write, 0);
        tick();
        drive(4'h0, 2'b00, 6'b001000, 4'h5, 2'b00, 4'h0);
        sample();
        chk("eq_after_cmp", reg_write, 1);
        tick();
        drive(4'h1, 2'b00, 6'b001000, 4'h5, 2'b00, 4'h0);
        sample();
        chk("ne_after_cmp", reg_write, 0);
        tick();

        // STR / LDR
        drive(4'hE, 2'b01, 6'b011000, 4'h3, 2'b00, 4'h0);
        sample();
        chk("str_mem_write", mem_write, 1);
        chk("str_reg_src", reg_src, 2'b10);
        tick();
        drive(4'hE, 2'b01, 6'b011001, 4'h3, 2'b00, 4'h0);
        sample();
        chk("ldr_mem_reg", mem_reg, 1);
        chk("ldr_reg_write", reg_write, 1);
        tick();

        // Branch and write to R15
        drive(4'hE, 2'b10, 6'b000000, 4'h0, 2'b00, 4'h0);
        sample();
        chk("b_pc_src", pc_src, 1);
        chk("b_imm_src", imm_src, 2'b10);
        tick();
        drive(4'hE, 2'b00, 6'b001000, 4'hF, 2'b00, 4'h0);
        sample();
        chk("r15_pc_src", pc_src, 1);
        tick();

        // Reset alongside a flag-setting instruction: reset wins.
        rst = 1'b1;
        drive(4'hE, 2'b00, 6'b010101, 4'h0, 2'b00, 4'hF);
        sample();
        tick();
        rst = 1'b0;
        drive(4'h4, 2'b00, 6'b001000, 4'h2, 2'b00, 4'h0);   // MI after reset
        sample();
        chk("mi_after_rst", reg_write, 0);
        tick();

        // Randomized program with occasional reset.
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 24) == 0);
            drive(($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom), 2'($urandom), 6'($urandom),
                  ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom), 2'($urandom), 4'($urandom));
            // bias toward flag-setting DP ops so conditions see varied flags
            if ($urandom_range(0, 2) == 0) begin op = 2'b00; funct[0] = 1'b1; end
            sample();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
